// File: rtl/basemul.sv
// basemul: Kyber base-case multiply (a0 + a1*X)(b0 + b1*X) mod (X^2 - zeta) using Montgomery reduction (q = 3329, R = 2^16).
// Optional macro BASEMUL_CANONICAL_EN adds a CANON state mapping r into [0, q-1] (latency 7 instead of 6).
`ifndef KYBER_POLY_WIDTH
`define KYBER_POLY_WIDTH 16
`endif

module basemul (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start,
  input  logic signed [`KYBER_POLY_WIDTH-1:0] a [0:1],
  input  logic signed [`KYBER_POLY_WIDTH-1:0] b [0:1],
  input  logic signed [`KYBER_POLY_WIDTH-1:0] zeta,
  output logic signed [`KYBER_POLY_WIDTH-1:0] r [0:1],
  output logic                                valid
);

  localparam int W  = `KYBER_POLY_WIDTH;
  localparam int PW = 2 * W;
  localparam logic        [W-1:0] QINV = W'(-3327);
  localparam logic signed [W-1:0] Q    = W'(3329);

  typedef enum logic [2:0] {IDLE, MUL, RED1, ZMUL, RED2, SUM, CANON} state_t;

`ifdef BASEMUL_CANONICAL_EN
  localparam state_t LAST = CANON;
`else
  localparam state_t LAST = SUM;
`endif

  state_t state;
  state_t next_state;

  logic signed [W-1:0]  a_q [0:1];
  logic signed [W-1:0]  b_q [0:1];
  logic signed [W-1:0]  zeta_q;
  logic                 mul_phase;
  logic signed [PW-1:0] prod [0:3];
  logic signed [W-1:0]  red [0:3];
  logic signed [W-1:0]  red_z;
  logic signed [W-1:0]  red_in [0:3];
  logic signed [W-1:0]  x0, y0, x1, y1;
  logic signed [PW-1:0] p0, p1;
  logic                 accept;
  logic                 done;
`ifdef BASEMUL_CANONICAL_EN
  logic signed [W-1:0]  sum0, sum1;
`endif

  // Montgomery reduction: returns p * R^-1 mod q, in (-q, q) for in-range operands
  function automatic logic signed [W-1:0] mont_reduce(input logic signed [PW-1:0] p);
    logic        [W-1:0]  t;
    logic signed [PW-1:0] u;
    t = p[W-1:0] * QINV;
    u = p - PW'($signed(t)) * PW'(Q);
    return u[PW-1:W];
  endfunction

`ifdef BASEMUL_CANONICAL_EN
  function automatic logic signed [W-1:0] canon(input logic signed [W-1:0] x);
    logic signed [W-1:0] y;
    y = x;
    if (y < 0) y = y + Q;
    if (y < 0) y = y + Q;
    if (y >= Q) y = y - Q;
    if (y >= Q) y = y - Q;
    return y;
  endfunction
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // The last state doubles as an accept slot so back-to-back operations run at full rate
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:  if (start) next_state = MUL;
      MUL:   if (mul_phase) next_state = RED1;
      RED1:  next_state = ZMUL;
      ZMUL:  next_state = RED2;
      RED2:  next_state = SUM;
`ifdef BASEMUL_CANONICAL_EN
      SUM:   next_state = CANON;
      CANON: next_state = start ? MUL : IDLE;
`else
      SUM:   next_state = start ? MUL : IDLE;
      CANON: next_state = IDLE;
`endif
      default: next_state = IDLE;
    endcase
  end

  // Two shared multipliers: direct products over two MUL cycles, then the zeta product in ZMUL
  always_comb begin
    accept = start && (state == IDLE || state == LAST);
    done   = (state == LAST);
    x0 = a_q[0];
    y0 = b_q[0];
    x1 = a_q[1];
    y1 = b_q[1];
    if (state == MUL && mul_phase) begin
      y0 = b_q[1];
      y1 = b_q[0];
    end else if (state == ZMUL) begin
      x0 = red[1];
      y0 = zeta_q;
    end
  end

  assign p0 = PW'(x0) * PW'(y0);
  assign p1 = PW'(x1) * PW'(y1);

  always_comb begin
    for (int i = 0; i < 4; i++) red_in[i] = mont_reduce(prod[i]);
  end

  // RED2 reuses reducer 0 because the zeta product is parked in prod[0]
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
        r[i]   <= '0;
      end
      for (int i = 0; i < 4; i++) begin
        prod[i] <= '0;
        red[i]  <= '0;
      end
      zeta_q    <= '0;
      mul_phase <= 1'b0;
      red_z     <= '0;
      valid     <= 1'b0;
`ifdef BASEMUL_CANONICAL_EN
      sum0      <= '0;
      sum1      <= '0;
`endif
    end else begin
      valid <= done;
      if (accept) begin
        a_q[0] <= a[0];
        a_q[1] <= a[1];
        b_q[0] <= b[0];
        b_q[1] <= b[1];
        zeta_q <= zeta;
      end
      unique case (state)
        MUL: begin
          mul_phase <= ~mul_phase;
          if (!mul_phase) begin
            prod[0] <= p0;
            prod[1] <= p1;
          end else begin
            prod[2] <= p0;
            prod[3] <= p1;
          end
        end
        RED1: begin
          for (int i = 0; i < 4; i++) red[i] <= red_in[i];
        end
        ZMUL: prod[0] <= p0;
        RED2: red_z <= red_in[0];
`ifdef BASEMUL_CANONICAL_EN
        SUM: begin
          sum0 <= red_z + red[0];
          sum1 <= red[2] + red[3];
        end
        CANON: begin
          r[0] <= canon(sum0);
          r[1] <= canon(sum1);
        end
`else
        SUM: begin
          r[0] <= red_z + red[0];
          r[1] <= red[2] + red[3];
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_basemul.sv
// tb_basemul: directed and model-checked vectors for basemul, including reset abort, ignored starts and input stability.
// Honours BASEMUL_CANONICAL_EN (latency 7, results mapped into [0, q-1]).
`timescale 1ns/1ps

module tb_basemul;

`ifdef BASEMUL_CANONICAL_EN
  localparam int LAT = 7;
`else
  localparam int LAT = 6;
`endif

  logic               clk;
  logic               rst_n;
  logic               start;
  logic signed [15:0] a [0:1];
  logic signed [15:0] b [0:1];
  logic signed [15:0] zeta;
  logic signed [15:0] r [0:1];
  logic               valid;

  int checks;
  int failures;

  basemul dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .zeta  (zeta),
    .r     (r),
    .valid (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference Montgomery multiply written with integer division rather than bit slicing
  function automatic int fq(int x, int y);
    longint p, t;
    p = longint'(x) * longint'(y);
    t = (p * -3327) % 65536;
    if (t >= 32768) t -= 65536;
    else if (t < -32768) t += 65536;
    return int'((p - t * 3329) / 65536);
  endfunction

  function automatic int expv(int x);
`ifdef BASEMUL_CANONICAL_EN
    return ((x % 3329) + 3329) % 3329;
`else
    return x;
`endif
  endfunction

  function automatic logic signed [15:0] rnd16();
`ifdef BASEMUL_CANONICAL_EN
    return 16'(int'($urandom_range(6656)) - 3328);
`else
    return 16'($urandom());
`endif
  endfunction

  task automatic checkOutput(input string tag, input logic signed [31:0] got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic setInputs(input logic signed [15:0] a0, a1, b0, b1, z);
    a[0] = a0;
    a[1] = a1;
    b[0] = b0;
    b[1] = b1;
    zeta = z;
  endtask

  task automatic applyStimulus(input logic signed [15:0] a0, a1, b0, b1, z);
    @(negedge clk);
    setInputs(a0, a1, b0, b1, z);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at the negedge after the start edge; lat is cycles from that edge to valid, 0 on timeout
  task automatic waitValid(input bit scramble, output int lat);
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      if (scramble) setInputs(rnd16(), rnd16(), rnd16(), rnd16(), rnd16());
      @(posedge clk);
      #1;
      if (valid) begin
        lat = c;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic runOp(input string tag, input logic signed [15:0] a0, a1, b0, b1, z,
                       input int e0, input int e1, input bit scramble);
    int lat;
    applyStimulus(a0, a1, b0, b1, z);
    waitValid(scramble, lat);
    checkOutput({tag, "_lat"}, lat, LAT);
    checkOutput({tag, "_r0"}, r[0], e0);
    checkOutput({tag, "_r1"}, r[1], e1);
    @(posedge clk);
    #1;
    checkOutput({tag, "_vdrop"}, valid, 0);
    checkOutput({tag, "_hold"}, r[0], e0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int pulses, first, lat;
    logic signed [15:0] ra0, ra1, rb0, rb1, rz, s0, s1;
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    setInputs(0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_valid", valid, 0);
    checkOutput("reset_r0", r[0], 0);
    checkOutput("reset_r1", r[1], 0);
    @(negedge clk);
    rst_n = 1'b1;

    runOp("one", 1, 0, 2285, 0, 17, expv(1), expv(0), 0);
    runOp("two", 1, 1, 2285, 2285, 2285, expv(2), expv(2), 0);
    runOp("neg", -1, 0, 2285, 0, 0, expv(-1), expv(0), 0);

    // Reset mid-flight: clears r, discards the operation
    applyStimulus(1, 1, 2285, 2285, 2285);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_valid", valid, 0);
    checkOutput("rst_r0", r[0], 0);
    checkOutput("rst_r1", r[1], 0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (valid) pulses++;
    end
    checkOutput("rst_discard", pulses, 0);
    runOp("after_rst", 1, 1, 2285, 2285, 2285, expv(2), expv(2), 0);

    // Ignored start two cycles in, accepted start on the valid edge
    applyStimulus(0, 1, 0, 2285, 2285);
    pulses = 0;
    first  = 0;
    for (int c = 1; c <= LAT; c++) begin
      if (c == 2) begin
        setInputs(7, 7, 9, 9, 3);
        start = 1'b1;
      end else if (c == LAT) begin
        setInputs(1, 1, 2285, 2285, 2285);
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      if (valid) begin
        pulses++;
        if (first == 0) first = c;
      end
      if (c == LAT) begin
        checkOutput("b2b_r0", r[0], expv(1));
        checkOutput("b2b_r1", r[1], expv(0));
      end
      @(negedge clk);
    end
    start = 1'b0;
    checkOutput("b2b_pulses", pulses, 1);
    checkOutput("b2b_first", first, LAT);
    waitValid(0, lat);
    checkOutput("b2b_next_lat", lat, LAT);
    checkOutput("b2b_next_r0", r[0], expv(2));
    checkOutput("b2b_next_r1", r[1], expv(2));

    runOp("stable", 1, 1, 2285, 2285, 2285, expv(2), expv(2), 1);

    for (int i = 0; i < 1000; i++) begin
      ra0 = rnd16();
      ra1 = rnd16();
      rb0 = rnd16();
      rb1 = rnd16();
      rz  = rnd16();
      s0  = 16'(fq(fq(ra1, rb1), rz) + fq(ra0, rb0));
      s1  = 16'(fq(ra0, rb1) + fq(ra1, rb0));
      runOp("rand", ra0, ra1, rb0, rb1, rz, expv(int'(s0)), expv(int'(s1)), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
